// File: rtl/mm_pkg.sv
// Shared types and address mapping for the tile loader / skew feeder pair.
package mm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } feeder_st_t;

    // Bank-set select lands in address bit aw-1; k fills the bits below it.
    function automatic logic [31:0] bank_addr(input logic bankset, input logic [15:0] k,
                                              input int aw);
        return (32'(bankset) << (aw - 1)) | ({16'd0, k} & ((32'd1 << (aw - 1)) - 32'd1));
    endfunction

endpackage

// File: rtl/skew_feeder_skew_line.sv
// Stall-aware delay line carrying a valid bit: DEPTH shift stages plus an output register.
module skew_line #(
    parameter int W     = 8,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    output logic         pending
);
    logic         tail_vld;
    logic [W-1:0] tail_data;
    logic [W-1:0] out_q;

    generate
        if (DEPTH == 0) begin : g_direct
            assign tail_vld  = in_vld;
            assign tail_data = in_data;
            assign pending   = 1'b0;
        end else begin : g_shift
            logic [DEPTH-1:0] vld_q;
            logic [W-1:0]     data_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else if (!stall) begin
                    vld_q[0] <= in_vld;
                    for (int s = 1; s < DEPTH; s++) vld_q[s] <= vld_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!stall) begin
                    data_q[0] <= in_data;
                    for (int s = 1; s < DEPTH; s++) data_q[s] <= data_q[s-1];
                end
            end

            assign tail_vld  = vld_q[DEPTH-1];
            assign tail_data = data_q[DEPTH-1];
            assign pending   = |vld_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      out_vld <= 1'b0;
        else if (!stall) out_vld <= tail_vld;
    end

    always_ff @(posedge clk) begin
        if (!stall) out_q <= tail_data;
    end

    // Data registers carry no reset; the valid bit masks them instead.
    assign out_data = out_vld ? out_q : '0;

endmodule

// File: rtl/skew_feeder.sv
// Reads one element per bank per cycle and skews lane i by i cycles into the systolic array edge.
module skew_feeder
    import mm_pkg::*;
#(
    parameter int W  = 8,
    parameter int T  = 16,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [15:0]     tile_len_k,
    input  logic            bankset_sel,
    input  logic            stall,
    output logic [T-1:0]    a_en,
    output logic [T*AW-1:0] a_addr,
    input  logic [T*W-1:0]  a_dout,
    output logic [T*W-1:0]  out_data,
    output logic [T-1:0]    out_valid
);
    feeder_st_t     state, state_nxt;
    logic [15:0]    len_q;
    logic [15:0]    k;
    logic           bankset_q;
    logic           rd_vld_q;
    logic           hold_vld;
    logic [T*W-1:0] hold_data;
    logic           issue;
    logic           drained;
    logic           line_vld;
    logic [T*W-1:0] line_data;
    logic [T-1:0]   line_pending;
    logic [AW-1:0]  rd_addr;

    // A held word always drains on the first unstalled edge, so issuing on that
    // same edge cannot collide with it; this keeps a stall from costing an extra cycle.
    assign issue = (state == S_READ) && (len_q != 16'd0) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_q     <= '0;
            bankset_q <= 1'b0;
            k         <= '0;
            rd_vld_q  <= 1'b0;
            hold_vld  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rd_vld_q <= issue;
            if (state == S_IDLE && start) begin
                len_q     <= tile_len_k;
                bankset_q <= bankset_sel;
                k         <= '0;
            end else if (issue) begin
                k <= k + 16'd1;
            end
            if (rd_vld_q && stall) hold_vld <= 1'b1;
            else if (!stall)       hold_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld_q && stall) hold_data <= a_dout;
    end

    // Look one edge ahead so done follows the last valid output directly.
    assign drained = !line_vld && (line_pending == '0) && (!stall || out_valid == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  if (len_q == 16'd0 || (issue && k == len_q - 16'd1)) state_nxt = S_DRAIN;
            S_DRAIN: if (drained) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy    = (state == S_READ) || (state == S_DRAIN);
    assign done    = (state == S_DONE);
    assign a_en    = {T{issue}};
    assign rd_addr = AW'(bank_addr(bankset_q, k, AW));
    assign a_addr  = {T{rd_addr}};

    assign line_vld  = rd_vld_q || hold_vld;
    assign line_data = hold_vld ? hold_data : a_dout;

    for (genvar i = 0; i < T; i++) begin : g_lane
        skew_line #(
            .W     (W),
            .DEPTH (i)
        ) u_line (
            .clk      (clk),
            .rst_n    (rst_n),
            .stall    (stall),
            .in_vld   (line_vld),
            .in_data  (line_data[i*W +: W]),
            .out_vld  (out_valid[i]),
            .out_data (out_data[i*W +: W]),
            .pending  (line_pending[i])
        );
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder: T=4 lanes, bank i holds 16*i+k (+128 for bank set 1).
module tb_skew_feeder;
    localparam int W  = 8;
    localparam int T  = 4;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done;
    logic [15:0]     tile_len_k = '0;
    logic            bankset_sel = 1'b0;
    logic            stall = 1'b0;
    logic [T-1:0]    a_en;
    logic [T*AW-1:0] a_addr;
    logic [T*W-1:0]  a_dout = '0;
    logic [T*W-1:0]  out_data;
    logic [T-1:0]    out_valid;

    int tests = 0;
    int fails = 0;

    int            rec_n   [T];
    int            rec_cyc [T][64];
    logic [W-1:0]  rec_dat [T][64];
    int            n_iss;
    int            iss_cyc [64];
    logic [AW-1:0] iss_addr[64];

    skew_feeder #(.W(W), .T(T), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .tile_len_k  (tile_len_k),
        .bankset_sel (bankset_sel),
        .stall       (stall),
        .a_en        (a_en),
        .a_addr      (a_addr),
        .a_dout      (a_dout),
        .out_data    (out_data),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_val(input int lane, input logic [AW-1:0] addr);
        return W'(16 * lane + int'(addr[3:0]) + (addr[AW-1] ? 128 : 0));
    endfunction

    // Synchronous-read BRAM: data appears one cycle after a_en.
    always @(posedge clk) begin
        if (a_en[0])
            for (int i = 0; i < T; i++) a_dout[i*W +: W] <= mem_val(i, a_addr[i*AW +: AW]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // A nominal (stall-free) edge at or after the stall window moves out by its length.
    function automatic int mapc(input int e, input int s0, input int s1);
        return (s1 >= s0 && e >= s0) ? e + (s1 - s0 + 1) : e;
    endfunction

    // Cycle n = values just after edge n, where edge 0 samples start.
    // a_en seen before edge n+1 is the issue taken at edge n+1.
    task automatic run(input int K, input bit bs, input int s0, input int s1,
                       input int flip_n, input string name);
        int           n;
        bit           fin;
        int           done_cyc;
        logic         busy_at_done;
        int           bad;
        int           exp_done;
        logic [T-1:0] pv;
        logic [T*W-1:0] pd;
        n_iss = 0;
        for (int i = 0; i < T; i++) rec_n[i] = 0;
        fin = 0; done_cyc = -1; busy_at_done = 1'b1; bad = 0;
        pv = '0; pd = '0;
        @(negedge clk);
        start = 1'b1; tile_len_k = 16'(K); bankset_sel = bs; stall = 1'b0;
        @(posedge clk);
        n = 0;
        while (!fin && n < 300) begin
            @(negedge clk);
            if (n >= s0 && n <= s1) begin
                check({name, " freeze_valid"}, 64'(out_valid), 64'(pv));
                check({name, " freeze_data"}, 64'(out_data), 64'(pd));
            end else begin
                for (int i = 0; i < T; i++) begin
                    if (out_valid[i]) begin
                        if (rec_n[i] < 64) begin
                            rec_cyc[i][rec_n[i]] = n;
                            rec_dat[i][rec_n[i]] = out_data[i*W +: W];
                        end
                        rec_n[i]++;
                    end
                end
            end
            for (int i = 0; i < T; i++)
                if (!out_valid[i] && out_data[i*W +: W] != '0) bad++;
            if (done) begin
                fin = 1; done_cyc = n; busy_at_done = busy;
            end
            pv = out_valid; pd = out_data;
            start = 1'b0;
            stall = (n + 1 >= s0 && n + 1 <= s1);
            if (n == flip_n) bankset_sel = ~bs;
            #1;
            if (a_en != '0) begin
                if (a_en != '1) bad++;
                for (int j = 1; j < T; j++)
                    if (a_addr[j*AW +: AW] !== a_addr[AW-1:0]) bad++;
                if (n_iss < 64) begin
                    iss_cyc[n_iss]  = n + 1;
                    iss_addr[n_iss] = a_addr[AW-1:0];
                end
                n_iss++;
            end
            if (!fin) begin
                @(posedge clk);
                n++;
            end
        end
        stall = 1'b0;
        exp_done = (K == 0) ? 2 : mapc(K + T + 1, s0, s1);
        check({name, " done_seen"}, 64'(fin), 64'd1);
        check({name, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({name, " busy_at_done"}, 64'(busy_at_done), 64'd0);
        check({name, " zero_and_lane_consistency"}, 64'(bad), 64'd0);
        check({name, " issue_count"}, 64'(n_iss), 64'(K));
        for (int j = 0; j < n_iss && j < 64; j++) begin
            check($sformatf("%s issue%0d_cycle", name, j), 64'(iss_cyc[j]), 64'(mapc(1 + j, s0, s1)));
            check($sformatf("%s issue%0d_addr", name, j), 64'(iss_addr[j]), 64'((bs ? 512 : 0) + j));
        end
        for (int i = 0; i < T; i++) begin
            check($sformatf("%s lane%0d_count", name, i), 64'(rec_n[i]), 64'(K));
            for (int j = 0; j < rec_n[i] && j < 64; j++) begin
                check($sformatf("%s lane%0d_k%0d_data", name, i, j), 64'(rec_dat[i][j]),
                      64'(16 * i + j + (bs ? 128 : 0)));
                check($sformatf("%s lane%0d_k%0d_cycle", name, i, j), 64'(rec_cyc[i][j]),
                      64'(mapc(2 + i + j, s0, s1)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset a_en", 64'(a_en), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset a_addr", 64'(a_addr), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(3, 1'b0, 0, -1, -1, "k3");
        run(0, 1'b0, 0, -1, -1, "k0");
        run(5, 1'b0, 3, 5, -1, "stall3");
        run(4, 1'b0, 2, 2, -1, "ret_stall");
        run(3, 1'b1, 0, -1, 1, "bankset");

        // Asynchronous reset while draining a K=3 run on bank set 1.
        @(negedge clk);
        start = 1'b1; tile_len_k = 16'd3; bankset_sel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst busy", 64'(busy), 64'd1);
        check("pre_rst out_valid_nonzero", 64'(out_valid != '0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", 64'(out_data), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst a_en", 64'(a_en), 64'd0);
        check("rst a_addr", 64'(a_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst no_done", 64'(done_cnt), 64'd0);
        check("rst idle_busy", 64'(busy), 64'd0);
        run(2, 1'b0, 0, -1, -1, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
